// File: rtl/oe_cfg_pkg.sv
// Shared types and constants for the output-enable configuration loader.
package oe_cfg_pkg;

    // Frame reception states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_PAR,
        ST_DONE,
        ST_ERR
    } state_e;

    // Width of one macrocell output-enable mux field.
    localparam int OE_FIELD_W = 3;

    // Frame sync byte used unless the instance overrides it.
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Named oe_mux codes. The loader treats them as opaque data.
    localparam logic [2:0] OE_OFF  = 3'b000;
    localparam logic [2:0] OE_GOE0 = 3'b001;
    localparam logic [2:0] OE_GOE1 = 3'b100;
    localparam logic [2:0] OE_GOE2 = 3'b101;
    localparam logic [2:0] OE_GOE3 = 3'b010;
    localparam logic [2:0] OE_GOE4 = 3'b011;
    localparam logic [2:0] OE_GOE5 = 3'b110;
    localparam logic [2:0] OE_PT5  = 3'b111;

endpackage

// File: rtl/oe_cfg_loader.sv
// Serial loader for the per-macrocell oe_mux fields. A frame is a sync
// header, the payload, and an even-parity bit. The payload is assembled
// in a shadow register and only copied to the live outputs once the whole
// frame has checked out, so the GOE selectors never see a partial update.
module oe_cfg_loader
    import oe_cfg_pkg::*;
#(
    parameter int         NUM_MC = 16,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic                         cfg_abort,
    input  logic                         cfg_bit,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [OE_FIELD_W*NUM_MC-1:0] oe_mux_flat
);

    localparam int PAY_W = OE_FIELD_W * NUM_MC;
    localparam int CNT_W = $clog2(PAY_W + 9);

    // Counter values of the last header bit and the last payload bit.
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(8 + PAY_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         hdr_q, hdr_d;
    logic [PAY_W-1:0]   shadow_q, shadow_d;
    logic               par_q, par_d;
    logic [PAY_W-1:0]   oe_q, oe_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               xfer;

    // ready_q is high exactly in the bit-accepting states, so it doubles as the handshake qualifier.
    assign xfer = cfg_valid && ready_q;

    // Next-state and next-output logic; abort outranks start, which outranks any bit transfer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        shadow_d = shadow_q;
        par_d    = par_q;
        oe_d     = oe_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        if (cfg_abort) begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
            busy_d  = 1'b0;
        end else if (cfg_start) begin
            state_d  = ST_HDR;
            cnt_d    = '0;
            hdr_d    = '0;
            shadow_d = '0;
            par_d    = 1'b0;
            err_d    = 1'b0;
            ready_d  = 1'b1;
            busy_d   = 1'b1;
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (xfer) begin
                        hdr_d = {hdr_q[5:0], cfg_bit};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == HDR_LAST) begin
                            if ({hdr_q, cfg_bit} == HEADER) begin
                                state_d = ST_PAY;
                            end else begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                                ready_d = 1'b0;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_PAY: begin
                    if (xfer) begin
                        // Shifting in from the top leaves the first payload bit at shadow bit 0.
                        shadow_d = {cfg_bit, shadow_q[PAY_W-1:1]};
                        par_d    = par_q ^ cfg_bit;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == PAY_LAST) begin
                            state_d = ST_PAR;
                        end
                    end
                end
                ST_PAR: begin
                    if (xfer) begin
                        ready_d = 1'b0;
                        busy_d  = 1'b0;
                        if ((par_q ^ cfg_bit) == 1'b0) begin
                            state_d = ST_DONE;
                            oe_d    = shadow_q;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs; reset discards any frame and disables every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hdr_q    <= '0;
            shadow_q <= '0;
            par_q    <= 1'b0;
            oe_q     <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
            shadow_q <= shadow_d;
            par_q    <= par_d;
            oe_q     <= oe_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign oe_mux_flat = oe_q;

endmodule

// File: tb/tb_oe_cfg_loader.sv
// Directed bench for oe_cfg_loader with two macrocells.
module tb_oe_cfg_loader;
    import oe_cfg_pkg::*;

    localparam int NUM_MC = 2;
    localparam int PAY_W  = 3 * NUM_MC;

    logic             clk;
    logic             rst;
    logic             cfg_start;
    logic             cfg_abort;
    logic             cfg_bit;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [PAY_W-1:0] oe_mux_flat;

    int total;
    int bad;
    logic [PAY_W-1:0] prevOe;

    typedef struct {
        logic [7:0]       hdr;
        logic [PAY_W-1:0] payload;
        logic             flip;
        int               gap;
        logic [PAY_W-1:0] expOe;
        logic             expErr;
    } vec_t;

    vec_t vecs [6];

    oe_cfg_loader #(
        .NUM_MC (NUM_MC),
        .HEADER (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_abort   (cfg_abort),
        .cfg_bit     (cfg_bit),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .oe_mux_flat (oe_mux_flat)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one bit after some idle cycles; called and returns at a falling edge.
    task automatic sendBit(input logic b, input int gap);
        cfg_valid = 1'b0;
        repeat (gap) @(negedge clk);
        cfg_bit   = b;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // One-cycle cfg_start pulse.
    task automatic pulseStart();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    // Send a complete frame and check the outcome against the vector.
    task automatic applyStimulus(input vec_t v, input string tag);
        logic parBit;
        pulseStart();
        checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
        checkOutput({tag, " ready after start"}, 64'(cfg_ready), 64'd1);
        checkOutput({tag, " err cleared by start"}, 64'(err), 64'd0);
        for (int i = 7; i >= 0; i--) sendBit(v.hdr[i], v.gap);
        if (v.hdr != 8'hA5) begin
            checkOutput({tag, " err after bad header"}, 64'(err), 64'd1);
            checkOutput({tag, " ready after bad header"}, 64'(cfg_ready), 64'd0);
            checkOutput({tag, " busy after bad header"}, 64'(busy), 64'd0);
            sendBit(1'b1, 0);
            checkOutput({tag, " ready stays low in ERR"}, 64'(cfg_ready), 64'd0);
            checkOutput({tag, " oe kept on bad header"}, 64'(oe_mux_flat), 64'(v.expOe));
            checkOutput({tag, " no done on bad header"}, 64'(done), 64'd0);
        end else begin
            checkOutput({tag, " ready in payload"}, 64'(cfg_ready), 64'd1);
            for (int i = 0; i < PAY_W; i++) sendBit(v.payload[i], v.gap);
            checkOutput({tag, " oe before parity"}, 64'(oe_mux_flat), 64'(prevOe));
            parBit = (^v.payload) ^ v.flip;
            sendBit(parBit, v.gap);
            checkOutput({tag, " oe at parity edge"}, 64'(oe_mux_flat), 64'(v.expOe));
            checkOutput({tag, " done pulse"}, 64'(done), 64'(!v.expErr));
            checkOutput({tag, " err"}, 64'(err), 64'(v.expErr));
            checkOutput({tag, " ready after frame"}, 64'(cfg_ready), 64'd0);
            checkOutput({tag, " busy after frame"}, 64'(busy), 64'd0);
            @(negedge clk);
            checkOutput({tag, " done one cycle"}, 64'(done), 64'd0);
            checkOutput({tag, " ready stays low"}, 64'(cfg_ready), 64'd0);
        end
        prevOe = v.expOe;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        prevOe    = '0;
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_bit   = 1'b0;
        cfg_valid = 1'b0;

        vecs[0] = '{hdr: 8'hA5, payload: {OE_PT5, OE_GOE0},   flip: 1'b0, gap: 0,
                    expOe: 6'b111001, expErr: 1'b0};
        vecs[1] = '{hdr: 8'hA5, payload: {OE_GOE3, OE_GOE4},  flip: 1'b1, gap: 0,
                    expOe: 6'b111001, expErr: 1'b1};
        vecs[2] = '{hdr: 8'hA4, payload: {OE_OFF, OE_OFF},    flip: 1'b0, gap: 0,
                    expOe: 6'b111001, expErr: 1'b1};
        vecs[3] = '{hdr: 8'hA5, payload: {OE_GOE3, OE_GOE5},  flip: 1'b0, gap: 1,
                    expOe: 6'b010110, expErr: 1'b0};
        vecs[4] = '{hdr: 8'hA5, payload: {OE_PT5, OE_GOE0},   flip: 1'b0, gap: 3,
                    expOe: 6'b111001, expErr: 1'b0};
        vecs[5] = '{hdr: 8'hA5, payload: {OE_OFF, OE_OFF},    flip: 1'b0, gap: 0,
                    expOe: 6'b000000, expErr: 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("reset oe", 64'(oe_mux_flat), 64'd0);
        checkOutput("reset ready", 64'(cfg_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle oe", 64'(oe_mux_flat), 64'd0);
        checkOutput("idle ready", 64'(cfg_ready), 64'd0);
        checkOutput("idle busy", 64'(busy), 64'd0);
        checkOutput("idle done", 64'(done), 64'd0);
        checkOutput("idle err", 64'(err), 64'd0);

        for (int k = 0; k < 6; k++) applyStimulus(vecs[k], $sformatf("vec%0d", k));

        // Restart after three payload bits; a bit offered with the start is dropped.
        pulseStart();
        for (int i = 7; i >= 0; i--) sendBit(vecs[0].hdr[i], 0);
        for (int i = 0; i < 3; i++) sendBit(1'b1, 0);
        checkOutput("restart oe untouched", 64'(oe_mux_flat), 64'(prevOe));
        cfg_bit   = 1'b1;
        cfg_valid = 1'b1;
        applyStimulus('{hdr: 8'hA5, payload: {OE_GOE3, OE_GOE5}, flip: 1'b0, gap: 0,
                        expOe: 6'b010110, expErr: 1'b0}, "restart");

        // Abort together with start and a bit.
        pulseStart();
        for (int i = 7; i >= 4; i--) sendBit(vecs[0].hdr[i], 0);
        cfg_abort = 1'b1;
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        checkOutput("abort+start busy", 64'(busy), 64'd0);
        checkOutput("abort+start ready", 64'(cfg_ready), 64'd0);
        checkOutput("abort+start oe", 64'(oe_mux_flat), 64'(prevOe));

        // Abort during payload beats a simultaneous bit transfer.
        pulseStart();
        for (int i = 7; i >= 0; i--) sendBit(vecs[0].hdr[i], 0);
        sendBit(1'b1, 0);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        checkOutput("abort payload ready", 64'(cfg_ready), 64'd0);
        checkOutput("abort payload oe", 64'(oe_mux_flat), 64'(prevOe));
        @(negedge clk);
        checkOutput("abort payload done", 64'(done), 64'd0);

        // Asynchronous reset mid-frame clears the live fields at once.
        pulseStart();
        for (int i = 7; i >= 0; i--) sendBit(vecs[0].hdr[i], 0);
        for (int i = 0; i < 3; i++) sendBit(1'b0, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid reset oe", 64'(oe_mux_flat), 64'd0);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset ready", 64'(cfg_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        prevOe = '0;
        applyStimulus(vecs[0], "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
